// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg
//   Shared definitions for the hazard sequencer:
//     - state_e            : sequencer FSM state encoding (RUN / HOLD)
//     - FWD_RF/EXMEM/MEMWB : EX operand forward-select codes
//     - REG_AW_DEFAULT     : default register-address width
package hazard_sequencer_pkg;

  localparam int REG_AW_DEFAULT = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_sequencer_fwd_select.sv
// fwd_select
//   Combinational forward-select for one EX operand.
//   Ports:
//     src_reg        in  REG_AW  source register of the ID instruction
//     ex_rd          in  REG_AW  destination of the EX instruction
//     ex_reg_write   in  1       EX instruction writes a register
//     mem_rd         in  REG_AW  destination of the MEM instruction
//     mem_reg_write  in  1       MEM instruction writes a register
//     sel            out 2       FWD_EXMEM, FWD_MEMWB or FWD_RF
module fwd_select
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src_reg,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel
);

  // The younger producer (EX) wins over the older one (MEM); register 0
  // is hard-wired and never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (ex_reg_write && (ex_rd != '0) && (ex_rd == src_reg)) begin
      sel = FWD_EXMEM;
    end else if (mem_reg_write && (mem_rd != '0) && (mem_rd == src_reg)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline hazard control: memory-busy freeze, taken-branch flush,
//   load-use stall, jump flush, registered operand forwarding and
//   saturating stall/flush performance counters.
//   Ports:
//     clk, reset                     clock, async active-high reset
//     id_rs, id_rt, id_uses_rs/rt    ID instruction sources
//     id_jump                        ID instruction is an unconditional jump
//     ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken   EX stage info
//     mem_rd, mem_reg_write          MEM stage info
//     mem_busy                       data memory not ready -> freeze
//     pc_write, ifid_write, pipe_hold, ifid_flush, idex_bubble  controls
//     fwd_a, fwd_b                   registered EX operand selects
//     stall_cnt, flush_cnt           saturating performance counters
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              pipe_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e             state_q, state_d;
  logic [1:0]         fwd_a_q, fwd_a_d;
  logic [1:0]         fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [1:0]         sel_a, sel_b;
  logic               load_use;
  logic               in_hold;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_reg       (id_rs),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_reg       (id_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_b)
  );

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Transitions take effect in the same cycle as mem_busy changes, so the
  // controls are decoded from state_d (the state in force this cycle).
  // While reset is high the controls follow the RUN rules.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (mem_busy)  state_d = ST_HOLD;
      ST_HOLD: if (!mem_busy) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (reset) state_d = ST_RUN;
    in_hold = (state_d == ST_HOLD);

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (in_hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      // PC and IF-ID stay put, so a jump in ID is simply seen again next cycle.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end

    // A bubble entering EX carries no operands, so it gets the RF select.
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!in_hold) begin
      fwd_a_d = idex_bubble ? FWD_RF : sel_a;
      fwd_b_d = idex_bubble ? FWD_RF : sel_b;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
//   Scoreboard bench: each driven cycle pushes the expected control outputs
//   and expected post-edge register values; they are popped and compared
//   when the DUT presents them. A second instance with 4-bit counters shares
//   the stimulus so counter saturation is reached in a few cycles.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rs, id_uses_rt, id_jump;
  logic       ex_reg_write, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, mem_busy;

  logic        pc_write, ifid_write, pipe_hold, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_pipe_hold, s_ifid_flush, s_idex_bubble;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .pipe_hold(pipe_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_sequencer #(.REG_AW(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .pipe_hold(s_pipe_hold),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic pc; logic ifw; logic ifw_chk; logic ph; logic fl; logic bub;
  } comb_exp_t;

  typedef struct packed {
    logic [1:0] fa; logic [1:0] fb; logic [15:0] st; logic [15:0] fc;
    logic [3:0] sst; logic [3:0] sfc;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  logic [1:0] m_fa, m_fb;
  int         m_stall, m_flush;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] src);
    if (ex_reg_write && ex_rd != 4'd0 && ex_rd == src) return 2'b10;
    if (mem_reg_write && mem_rd != 4'd0 && mem_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic set_idle();
    id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 4'd0; mem_reg_write = 1'b0; mem_busy = 1'b0;
  endtask

  // Called just after a falling edge with the inputs already driven.
  task automatic cycle(input string what);
    comb_exp_t ce;
    reg_exp_t  re;
    logic      lu;
    lu = ex_mem_read && ex_rd != 4'd0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    ce = '0;
    ce.ifw_chk = 1'b1;
    if (mem_busy)             begin ce.ph = 1'b1; end
    else if (ex_branch_taken) begin ce.pc = 1'b1; ce.fl = 1'b1; ce.bub = 1'b1; ce.ifw_chk = 1'b0; end
    else if (lu)              begin ce.bub = 1'b1; end
    else if (id_jump)         begin ce.pc = 1'b1; ce.fl = 1'b1; ce.ifw_chk = 1'b0; end
    else                      begin ce.pc = 1'b1; ce.ifw = 1'b1; end
    if (!mem_busy) begin
      m_fa = ce.bub ? 2'b00 : ref_fwd(id_rs);
      m_fb = ce.bub ? 2'b00 : ref_fwd(id_rt);
    end
    if (!ce.pc) m_stall++;
    if (ce.fl)  m_flush++;
    re.fa  = m_fa;
    re.fb  = m_fb;
    re.st  = 16'(sat(m_stall, 65535));
    re.fc  = 16'(sat(m_flush, 65535));
    re.sst = 4'(sat(m_stall, 15));
    re.sfc = 4'(sat(m_flush, 15));
    comb_q.push_back(ce);
    reg_q.push_back(re);

    #2;
    ce = comb_q.pop_front();
    check_val({what, ".pc_write"},    32'(pc_write),    32'(ce.pc));
    check_val({what, ".pipe_hold"},   32'(pipe_hold),   32'(ce.ph));
    check_val({what, ".ifid_flush"},  32'(ifid_flush),  32'(ce.fl));
    check_val({what, ".idex_bubble"}, 32'(idex_bubble), 32'(ce.bub));
    check_val({what, ".s_pc_write"},  32'(s_pc_write),  32'(ce.pc));
    if (ce.ifw_chk) check_val({what, ".ifid_write"}, 32'(ifid_write), 32'(ce.ifw));

    @(posedge clk);
    #1;
    re = reg_q.pop_front();
    check_val({what, ".fwd_a"},       32'(fwd_a),       32'(re.fa));
    check_val({what, ".fwd_b"},       32'(fwd_b),       32'(re.fb));
    check_val({what, ".stall_cnt"},   32'(stall_cnt),   32'(re.st));
    check_val({what, ".flush_cnt"},   32'(flush_cnt),   32'(re.fc));
    check_val({what, ".s_stall_cnt"}, 32'(s_stall_cnt), 32'(re.sst));
    check_val({what, ".s_flush_cnt"}, 32'(s_flush_cnt), 32'(re.sfc));
    $display("cycle %0d %s: pc=%b hold=%b flush=%b bub=%b fa=%b fb=%b stall=%0d flushes=%0d",
             cyc, what, ce.pc, ce.ph, ce.fl, ce.bub, fwd_a, fwd_b, stall_cnt, flush_cnt);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    m_fa = 2'b00; m_fb = 2'b00; m_stall = 0; m_flush = 0;

    // Reset state; mem_busy is ignored while reset is high.
    reset = 1'b1;
    mem_busy = 1'b1;
    #3;
    check_val("rst.fwd_a",     32'(fwd_a),     32'd0);
    check_val("rst.fwd_b",     32'(fwd_b),     32'd0);
    check_val("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    check_val("rst.pipe_hold", 32'(pipe_hold), 32'd0);
    check_val("rst.pc_write",  32'(pc_write),  32'd1);
    mem_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    cycle("idle");

    // Load-use on rs (EX also writes r3, but the bubble forces RF select).
    set_idle(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
    id_rs = 4'd3; id_uses_rs = 1'b1;
    cycle("load_use_rs");
    set_idle(); cycle("after_load_use");

    // Load-use on rt.
    set_idle(); ex_mem_read = 1'b1; ex_rd = 4'd6; id_rt = 4'd6; id_uses_rt = 1'b1;
    cycle("load_use_rt");

    // Forwarding: EX beats MEM, then MEM only when ex_rd is 0.
    set_idle(); ex_reg_write = 1'b1; ex_rd = 4'd5; mem_reg_write = 1'b1; mem_rd = 4'd5;
    id_rt = 4'd5; cycle("fwd_b_exmem");
    ex_rd = 4'd0; cycle("fwd_b_memwb");
    set_idle(); mem_reg_write = 1'b1; mem_rd = 4'd9; id_rs = 4'd9; id_rt = 4'd9;
    ex_reg_write = 1'b1; ex_rd = 4'd2; cycle("fwd_ab_memwb");

    // Register 0 never hazards nor forwards.
    set_idle(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; mem_reg_write = 1'b1;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; cycle("reg0");

    // Branch wins over load-use.
    set_idle(); ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd3;
    id_rs = 4'd3; id_uses_rs = 1'b1; cycle("branch_lu");

    // Load-use defers a jump by one cycle.
    set_idle(); id_jump = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd4;
    id_rt = 4'd4; id_uses_rt = 1'b1; cycle("jump_lu");
    set_idle(); id_jump = 1'b1; cycle("jump_after_lu");

    // Memory busy for three cycles during a jump; flush on release.
    set_idle(); ex_reg_write = 1'b1; ex_rd = 4'd7; id_rs = 4'd7; cycle("fwd_before_hold");
    id_jump = 1'b1; mem_busy = 1'b1; ex_rd = 4'd1; id_rs = 4'd1; ex_branch_taken = 1'b1;
    cycle("hold1"); ex_branch_taken = 1'b0; cycle("hold2"); cycle("hold3");
    mem_busy = 1'b0; ex_reg_write = 1'b0; cycle("hold_release_jump");

    // Reset pulsed in the middle of a HOLD.
    set_idle(); ex_reg_write = 1'b1; ex_rd = 4'd8; id_rs = 4'd8; id_rt = 4'd8;
    cycle("fwd_before_rst");
    mem_busy = 1'b1; cycle("hold_pre_rst");
    reset = 1'b1;
    #1;
    check_val("rst_hold.fwd_a",     32'(fwd_a),     32'd0);
    check_val("rst_hold.fwd_b",     32'(fwd_b),     32'd0);
    check_val("rst_hold.stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst_hold.flush_cnt", 32'(flush_cnt), 32'd0);
    check_val("rst_hold.pipe_hold", 32'(pipe_hold), 32'd0);
    check_val("rst_hold.pc_write",  32'(pc_write),  32'd1);
    @(posedge clk);
    #1;
    check_val("rst_edge.stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst_edge.s_stall",   32'(s_stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    m_fa = 2'b00; m_fb = 2'b00; m_stall = 0; m_flush = 0;
    cycle("after_rst");

    // Saturation: 14 stalls bring the 4-bit counter to E, 3 more must stop at F.
    set_idle(); mem_busy = 1'b1;
    for (int i = 0; i < 17; i++) cycle("sat_hold");
    check_val("sat.s_stall_cnt", 32'(s_stall_cnt), 32'hF);
    set_idle(); cycle("sat_release");

    // Random traffic over a small register space to hit overlaps often.
    for (int i = 0; i < 150; i++) begin
      id_rs = 4'($urandom_range(0, 3));      id_rt = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3));      mem_rd = 4'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      ex_reg_write = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      id_jump = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
